// File: rtl/cla_multiword_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : cla_multiword_adder_if
// Description : Operand/result handshake bundle for the multi-word adder.
//               The master drives operands and consumes results. The slave
//               is the adder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface cla_multiword_adder_if #(
    parameter int WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   a;
    logic [16*WORDS-1:0]   b;
    logic                  ci;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   sum;
    logic                  co;
    logic                  ovf;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
endinterface
`default_nettype wire

// File: rtl/cla_multiword_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_16b / cla_multiword_adder
// Description : 16-bit two-level carry-lookahead adder, plus a sequencer that
//               reuses that single 16-bit adder to add WORDS-slice operands.
//               The sequencer processes one slice per cycle and carries
//               between slices through a register.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_16b (
    input  wire logic [15:0] A,
    input  wire logic [15:0] B,
    input  wire logic        CI,
    output logic      [15:0] S,
    output logic             CO
);
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_c;     // carry into each bit
    logic [3:0]  w_gp;    // group propagate
    logic [3:0]  w_gg;    // group generate

    assign w_p = A ^ B;
    assign w_g = A & B;

    // Per-group propagate/generate and in-group lookahead carries
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_group
            localparam int BASE = 4 * gi;
            assign w_gp[gi] = &w_p[BASE +: 4];
            assign w_gg[gi] = w_g[BASE+3]
                            | (w_p[BASE+3] & w_g[BASE+2])
                            | (w_p[BASE+3] & w_p[BASE+2] & w_g[BASE+1])
                            | (w_p[BASE+3] & w_p[BASE+2] & w_p[BASE+1] & w_g[BASE]);
            assign w_c[BASE+1] = w_g[BASE] | (w_p[BASE] & w_c[BASE]);
            assign w_c[BASE+2] = w_g[BASE+1] | (w_p[BASE+1] & w_g[BASE])
                               | (w_p[BASE+1] & w_p[BASE] & w_c[BASE]);
            assign w_c[BASE+3] = w_g[BASE+2] | (w_p[BASE+2] & w_g[BASE+1])
                               | (w_p[BASE+2] & w_p[BASE+1] & w_g[BASE])
                               | (w_p[BASE+2] & w_p[BASE+1] & w_p[BASE] & w_c[BASE]);
        end
    endgenerate

    // Second-level lookahead: carry into each 4-bit group and the carry-out
    assign w_c[0]  = CI;
    assign w_c[4]  = w_gg[0] | (w_gp[0] & CI);
    assign w_c[8]  = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & CI);
    assign w_c[12] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & CI);
    assign CO      = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & CI);

    assign S = w_p ^ w_c;
endmodule

module cla_multiword_adder #(
    parameter int WORDS = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cla_multiword_adder_if.slave bus
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_a   [WORDS];
    logic [15:0]      r_b   [WORDS];
    logic [15:0]      r_sum [WORDS];
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_co;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
    logic [15:0]      w_s;
    logic             w_co;
    logic             w_a_msb;
    logic             w_b_msb;

    // Ready is gated by rst directly so it drops the moment reset asserts
    assign w_in_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_a_msb    = r_a[WORDS-1][15];
    assign w_b_msb    = r_b[WORDS-1][15];

    cla_16b u_cla (
        .A  (r_a[r_idx]),
        .B  (r_b[r_idx]),
        .CI (r_carry),
        .S  (w_s),
        .CO (w_co)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: one RUN cycle per slice, then hold in DONE until taken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)      w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)        w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, slice sequencing, carry ripple and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                r_a[k]   <= 16'h0000;
                r_b[k]   <= 16'h0000;
                r_sum[k] <= 16'h0000;
            end
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                r_idx   <= '0;
                r_carry <= bus.ci;
                for (int k = 0; k < WORDS; k++) begin
                    r_a[k] <= bus.a[k*16 +: 16];
                    r_b[k] <= bus.b[k*16 +: 16];
                end
            end
        end else if (r_state == ST_RUN) begin
            r_sum[r_idx] <= w_s;
            r_carry      <= w_co;
            if (w_last) begin
                r_co  <= w_co;
                r_ovf <= (w_a_msb == w_b_msb) && (w_s[15] != w_a_msb);
            end else begin
                r_idx <= r_idx + c_IDX_ONE;
            end
        end
    end

    generate
        for (genvar k = 0; k < WORDS; k++) begin : g_pack
            assign bus.sum[k*16 +: 16] = r_sum[k];
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.co        = r_co;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: doc/cla_multiword_adder.md
# cla_multiword_adder

Sequential multi-word adder that drives a single `cla_16b` instance one 16-bit slice per cycle, rippling the carry through a register between slices. It sits directly upstream of `cla_16b`: it buffers wide operands, sequences the slices, and collects the wide sum. It presents valid/ready handshakes on both sides, so wide additions reuse the existing 16-bit carry-lookahead datapath instead of replicating it.

## Interface

- `WORDS`, default 4: number of 16-bit slices; operand width is 16*WORDS; legal range is WORDS >= 1.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `in_valid` input, 1: operand request.
- `in_ready` output, 1: block accepts operands; high only in IDLE and while `rst` is low.
- `a` input, 16*WORDS: operand A, unsigned or two's complement.
- `b` input, 16*WORDS: operand B.
- `ci` input, 1: carry-in to slice 0.
- `out_valid` output, 1: result available.
- `out_ready` input, 1: consumer takes the result.
- `sum` output, 16*WORDS: registered sum.
- `co` output, 1: carry-out of the top slice.
- `ovf` output, 1: signed overflow, defined as (a_msb == b_msb) && (sum_msb != a_msb).

## Operation

- Internal `cla_16b` instance:
  - `A` and `B` take slice `idx` of the latched operands.
  - `CI` takes the carry register.
  - `S` is written into slice `idx` of the sum register; `CO` loads the carry register.
- The block has three states: IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `a`, `b` and `ci` (into the carry register), clear `idx`, and go to RUN.
- **RUN**
  - Each cycle, compute slice `idx`, store its sum slice and carry, and increment `idx`.
  - When `idx`==WORDS-1, go to DONE after that cycle's update.
  - Latch `co` from the final carry and `ovf` from the latched operand MSBs and the final sum MSB.
- **DONE**
  - `out_valid`=1.
  - `sum`, `co` and `ovf` are held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0 in DONE. There is no same-cycle bypass into a new operation.
- `in_valid` and input data are ignored outside IDLE. Inputs may change freely after acceptance.
- `sum` bits above the slice currently being written are unspecified during RUN. They are valid only while `out_valid` is high.
- Arithmetic is modulo 2^(16*WORDS). `co` is the true carry-out, so {co, sum} = a + b + ci exactly.
- **Reset** (asynchronous, any state including mid-RUN):
  - state=IDLE, `idx`=0, carry=0, `sum`=0, `co`=0, `ovf`=0, `out_valid`=0.
  - `in_ready` is forced 0 while `rst` is high and returns to 1 once `rst` is low.
  - An aborted operation produces no result.

## Timing

- **Accept edge E0:** `in_valid && in_ready` sampled high.
- **RUN edges E1..E(WORDS):** slice k is registered at edge E(k+1).
- **Result:** `out_valid` rises after edge E(WORDS), so latency from the accept edge is WORDS cycles (4 at default).
- **Handoff:** `out_valid` falls on the edge where `out_ready` is sampled high; `in_ready` is high in the following cycle.
- **Throughput:** minimum spacing between accepts is WORDS+2 cycles (6 at default) with `out_ready` held high.
- **WORDS=1:** a single RUN cycle; `out_valid` is high one cycle after accept.
- **Combinational path:** the critical path is one `cla_16b` plus the slice mux; there is no combinational path from `out_ready` or `in_valid` to any output except `in_ready` via state.

## Test plan

Use WORDS=4 throughout.

- **Zero add:** a=0, b=0, ci=0 -> `sum`=0, `co`=0, `ovf`=0, `out_valid` high exactly 4 cycles after the accept edge.
- **Cross-slice carry:** a=0x0000_0000_0000_FFFF, b=1, ci=0 -> `sum`=0x0000_0000_0001_0000, `co`=0. Then a=0x0000_FFFF_FFFF_FFFF, b=0, ci=1 -> `sum`=0x0001_0000_0000_0000.
- **Full wrap:** a=0xFFFF_FFFF_FFFF_FFFF, b=1, ci=0 -> `sum`=0, `co`=1, `ovf`=0. Then a=b=0xFFFF_FFFF_FFFF_FFFF, ci=1 -> `sum`=0xFFFF_FFFF_FFFF_FFFF, `co`=1.
- **Signed overflow:** a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> `sum`=0x8000_0000_0000_0000, `ovf`=1, `co`=0. Then a=b=0x8000_0000_0000_0000 -> `sum`=0, `co`=1, `ovf`=1.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles after `out_valid` while `in_valid`=1 with a new operand pair.
  - Required: `in_ready`=0 throughout, `sum`/`co`/`ovf` stable.
  - Required: the new pair is accepted the cycle after `out_ready` pulses, and its result is correct.
- **Reset mid-operation:**
  - Assert `rst` asynchronously during RUN with `idx`=2.
  - Required: `out_valid`, `sum`, `co` and `ovf` are 0 immediately, and no result appears.
  - After release, `in_ready`=1; a subsequent 3+4 returns `sum`=7 after 4 cycles.
